ins_dec_buf: RTL and testbench
==============================

Name: ins_dec_buf

Overview:
Parametrised decode stage with an instruction buffer. It accepts IMEM fetch words holding LANES instructions each, and decodes every lane in parallel. Decoded entries are pushed into a DEPTH-entry queue with their PCs. The queue is presented to the execute stage one entry per cycle over a valid/ready handshake, with fetch backpressure and flush for redirects.

Parameters:
DATA_WIDTH, 32, IMEM word width; must be a multiple of INSTR_WIDTH
INSTR_WIDTH, 16, instruction width
ADDR_WIDTH, 32, byte-address width
DEPTH, 4, queue entries; power of 2, >= LANES
LANES (localparam), DATA_WIDTH/INSTR_WIDTH, instructions per fetch word

Ports:
clk_i  in  1  clock
arst_i  in  1  asynchronous active-high reset
imem_rdata_i  in  DATA_WIDTH  fetched word
imem_ack_i  in  1  fetched word valid this cycle
imem_addr_i  in  ADDR_WIDTH  byte address the word was fetched from
imem_ready_o  out  1  buffer can take a full word
flush_i  in  1  discard all buffered and incoming instructions
dec_valid_o  out  1  head entry valid
dec_ready_i  in  1  execute stage accepts head
func_o  out  func_t  opcode
we_o  out  1  RF write enable
rd_addr_o / rs1_addr_o / rs2_addr_o  out  3 each  register addresses
imm_o  out  6  unextended immediate
pc_o  out  ADDR_WIDTH  address of head instruction
valid_pc_o  out  1  0 = illegal opcode, PC must return to boot address
count_o  out  $clog2(DEPTH+1)  occupied entries
ovf_err_o  out  1  sticky: ack received while not ready

Behaviour:
- Reset (async, arst_i=1): pointers and count cleared, ovf_err_o=0, dec_valid_o=0, imem_ready_o=1. All entry-derived outputs read 0.
- Lane decode, per instruction:
  - rd=[15:13], rs1=[12:10], rs2=[9:7], imm=[9:4], func=[3:0].
  - legal = func in {ADDI, ADD, SUB, AND, OR, XOR, NOT, LOAD, STORE, SLL, SLR, SLLI, SLRI}.
  - valid_pc = legal.
  - we = legal && func!=STORE.
  - rd=0 is not special (used for NOP).
- Start lane s = imem_addr_i[$clog2(DATA_WIDTH/8)-1 : $clog2(INSTR_WIDTH/8)].
- Push: on imem_ack_i && imem_ready_o && !flush_i, lanes s..LANES-1 are written in ascending lane order.
  - Lane k gets pc = word-aligned base + k*(INSTR_WIDTH/8).
  - n_push = LANES-s.
- imem_ready_o = (DEPTH-count) >= LANES, computed from the registered count.
- Pop: dec_valid_o && dec_ready_i.
- dec_valid_o = (count != 0).
- Head fields are driven from storage at the read pointer, with no added register. All head fields are forced to 0 when empty.
- Latency: word acked in cycle N becomes visible in cycle N+1.
- Simultaneous push and pop in one cycle: count_next = count + n_push - pop. Pointers wrap modulo DEPTH.
- Flush has priority: flush_i=1 gives count=0 and pointers=0 next cycle; a same-cycle push is discarded.
- Ack while imem_ready_o=0: the word is dropped and ovf_err_o is set; it stays set until reset.
- A handshake is held: dec_valid_o cannot drop without a pop or flush, and head fields are stable while dec_ready_i=0.

Decomposition:
- simple_processor_pkg holds: DATA_WIDTH, ADDR_WIDTH, INSTR_WIDTH, func_t, and a dec_entry_t struct {func, we, rd, rs1, rs2, imm, pc, valid_pc}.
- Sub-module ins_dec_lane: a combinational single-instruction decoder, instantiated LANES times.
- Queue storage and control stay in the top module.

Test Plan:
1. Aligned fetch: ack addr 0x0, lanes {ADD rd3 rs1 1 rs2 2, SUB rd4 rs1 3 rs2 5}, dec_ready_i=1.
   - Next cycles: ADD pc 0x0 we=1, then SUB pc 0x2 we=1.
   - count_o sequence 2, 1, 0.
2. Unaligned fetch: ack addr 0x6 with lanes {AND, OR}.
   - Only OR is enqueued, pc 0x6, count_o=1.
3. Backpressure (DEPTH=4), dec_ready_i=0: two full words fill the queue to count 4, with imem_ready_o=0.
   - Pop one: count 3, imem_ready_o still 0.
   - Pop one more: count 2, imem_ready_o=1.
   - Head fields stay constant while stalled.
4. Illegal/STORE: a word with an undefined opcode and a STORE.
   - Illegal entry: valid_pc_o=0, we_o=0.
   - STORE entry: valid_pc_o=1, we_o=0.
5. Flush with a simultaneous ack at count 3: count_o=0 and dec_valid_o=0 next cycle; the acked word is absent.
6. Overflow, then reset mid-stream:
   - Ack while imem_ready_o=0 sets ovf_err_o=1 and keeps it set.
   - Assert arst_i mid-cycle: all outputs drop immediately to reset values.

Source files
------------

// File: rtl/simple_processor_pkg.sv
// ---------------------------------------------------------------------------
// simple_processor_pkg
// Shared widths, opcode enumeration and decoded-entry record for the
// decode stage and its instruction buffer.
// ---------------------------------------------------------------------------
package simple_processor_pkg;

    localparam int DATA_WIDTH  = 32;
    localparam int ADDR_WIDTH  = 32;
    localparam int INSTR_WIDTH = 16;

    // Opcode space is 4 bits; codes 13..15 are undefined (illegal).
    typedef enum logic [3:0] {
        ADD   = 4'd0,
        SUB   = 4'd1,
        AND   = 4'd2,
        OR    = 4'd3,
        XOR   = 4'd4,
        NOT   = 4'd5,
        ADDI  = 4'd6,
        SLL   = 4'd7,
        SLR   = 4'd8,
        SLLI  = 4'd9,
        SLRI  = 4'd10,
        LOAD  = 4'd11,
        STORE = 4'd12
    } func_t;

    typedef struct packed {
        func_t                 func;
        logic                  we;
        logic [2:0]            rd;
        logic [2:0]            rs1;
        logic [2:0]            rs2;
        logic [5:0]            imm;
        logic [ADDR_WIDTH-1:0] pc;
        logic                  valid_pc;
    } dec_entry_t;

    function automatic logic is_legal(input func_t f);
        case (f)
            ADD, SUB, AND, OR, XOR, NOT, ADDI,
            SLL, SLR, SLLI, SLRI, LOAD, STORE: return 1'b1;
            default:                           return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ins_dec_buf_if.sv
// ---------------------------------------------------------------------------
// ins_dec_buf_if
// Bundles the fetch-side bus (IMEM word, ack, address, ready), the flush
// request and the execute-side valid/ready head interface of ins_dec_buf.
//   slave  : the buffer's view (fetch/flush/dec_ready in, decoded head out)
//   master : the surrounding pipeline's view
// ---------------------------------------------------------------------------
interface ins_dec_buf_if #(
    parameter int DATA_WIDTH = simple_processor_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = simple_processor_pkg::ADDR_WIDTH,
    parameter int DEPTH      = 4
);
    // Fetch side
    logic [DATA_WIDTH-1:0]        imem_rdata_i;
    logic                         imem_ack_i;
    logic [ADDR_WIDTH-1:0]        imem_addr_i;
    logic                         imem_ready_o;
    logic                         flush_i;
    // Execute side
    logic                         dec_valid_o;
    logic                         dec_ready_i;
    simple_processor_pkg::func_t  func_o;
    logic                         we_o;
    logic [2:0]                   rd_addr_o;
    logic [2:0]                   rs1_addr_o;
    logic [2:0]                   rs2_addr_o;
    logic [5:0]                   imm_o;
    logic [ADDR_WIDTH-1:0]        pc_o;
    logic                         valid_pc_o;
    logic [$clog2(DEPTH+1)-1:0]   count_o;
    logic                         ovf_err_o;

    modport slave (
        input  imem_rdata_i, imem_ack_i, imem_addr_i, flush_i, dec_ready_i,
        output imem_ready_o, dec_valid_o, func_o, we_o, rd_addr_o, rs1_addr_o,
               rs2_addr_o, imm_o, pc_o, valid_pc_o, count_o, ovf_err_o
    );

    modport master (
        output imem_rdata_i, imem_ack_i, imem_addr_i, flush_i, dec_ready_i,
        input  imem_ready_o, dec_valid_o, func_o, we_o, rd_addr_o, rs1_addr_o,
               rs2_addr_o, imm_o, pc_o, valid_pc_o, count_o, ovf_err_o
    );
endinterface

// File: rtl/ins_dec_lane.sv
// ---------------------------------------------------------------------------
// ins_dec_lane
// Purely combinational decoder for one 16-bit instruction.
//   instr_i : raw instruction
//   pc_i    : byte address of this instruction
//   entry_o : decoded record (fields, write enable, legality, pc)
// ---------------------------------------------------------------------------
module ins_dec_lane
    import simple_processor_pkg::*;
(
    input  logic [INSTR_WIDTH-1:0] instr_i,
    input  logic [ADDR_WIDTH-1:0]  pc_i,
    output dec_entry_t             entry_o
);

    func_t func;
    logic  legal;

    assign func  = func_t'(instr_i[3:0]);
    assign legal = is_legal(func);

    // imm deliberately overlaps rs2: the format reuses those bits.
    always_comb begin
        entry_o.func     = func;
        entry_o.we       = legal && (func != STORE);
        entry_o.rd       = instr_i[15:13];
        entry_o.rs1      = instr_i[12:10];
        entry_o.rs2      = instr_i[9:7];
        entry_o.imm      = instr_i[9:4];
        entry_o.pc       = pc_i;
        entry_o.valid_pc = legal;
    end

endmodule

// File: rtl/ins_dec_buf.sv
// ---------------------------------------------------------------------------
// ins_dec_buf
// Decode stage with a DEPTH-entry instruction queue. Every fetched word is
// decoded lane-by-lane in parallel; lanes from the start lane upward are
// pushed with their PCs, and the queue head is offered to execute over a
// valid/ready handshake.
//   clk_i, arst_i : clock, asynchronous active-high reset
//   bus (slave)   : fetch word/ack/addr/ready, flush, dec_valid/dec_ready,
//                   decoded head fields, count_o, sticky ovf_err_o
// ---------------------------------------------------------------------------
module ins_dec_buf #(
    parameter int DATA_WIDTH  = simple_processor_pkg::DATA_WIDTH,
    parameter int INSTR_WIDTH = simple_processor_pkg::INSTR_WIDTH,
    parameter int ADDR_WIDTH  = simple_processor_pkg::ADDR_WIDTH,
    parameter int DEPTH       = 4
) (
    input  logic         clk_i,
    input  logic         arst_i,
    ins_dec_buf_if.slave bus
);
    import simple_processor_pkg::dec_entry_t;

    localparam int LANES       = DATA_WIDTH / INSTR_WIDTH;
    localparam int PTR_W       = $clog2(DEPTH);
    localparam int CNT_W       = $clog2(DEPTH + 1);
    localparam int WORD_BYTES  = DATA_WIDTH / 8;
    localparam int INSTR_SHIFT = $clog2(INSTR_WIDTH / 8);

    // ---------------- lane decode ----------------
    logic [ADDR_WIDTH-1:0] word_base;
    logic [ADDR_WIDTH-1:0] start_lane;
    dec_entry_t            lane_entry [LANES];

    assign word_base  = bus.imem_addr_i & ~ADDR_WIDTH'(WORD_BYTES - 1);
    assign start_lane = (bus.imem_addr_i & ADDR_WIDTH'(WORD_BYTES - 1)) >> INSTR_SHIFT;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        ins_dec_lane u_lane (
            .instr_i (bus.imem_rdata_i[k*INSTR_WIDTH +: INSTR_WIDTH]),
            .pc_i    (word_base + ADDR_WIDTH'(k * (INSTR_WIDTH / 8))),
            .entry_o (lane_entry[k])
        );
    end

    // ---------------- queue state ----------------
    dec_entry_t       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             ovf_q,    ovf_d;

    logic             ready;
    logic             push;
    logic             pop;
    logic [CNT_W-1:0] n_push;

    // Ready is derived from the registered count only, so it never depends
    // on same-cycle pops and has no combinational path from dec_ready_i.
    assign ready  = (CNT_W'(DEPTH) - count_q) >= CNT_W'(LANES);
    assign push   = bus.imem_ack_i && ready && !bus.flush_i;
    assign pop    = (count_q != '0) && bus.dec_ready_i;
    assign n_push = CNT_W'(LANES) - CNT_W'(start_lane);

    // ---------------- write steering ----------------
    logic [DEPTH-1:0] wr_en;
    dec_entry_t       wr_data [DEPTH];
    logic [PTR_W-1:0] slot;

    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned; otherwise a latch would be inferred.
    always_comb begin
        wr_en = '0;
        slot  = '0;
        for (int d = 0; d < DEPTH; d++) wr_data[d] = '0;
        if (push) begin
            for (int k = 0; k < LANES; k++) begin
                if (ADDR_WIDTH'(k) >= start_lane) begin
                    slot          = wr_ptr_q + PTR_W'(ADDR_WIDTH'(k) - start_lane);
                    wr_en[slot]   = 1'b1;
                    wr_data[slot] = lane_entry[k];
                end
            end
        end
    end

    // NOTE: the storage array has no reset; an entry is only ever read
    // once count covers it, so its power-up contents are irrelevant.
    always_ff @(posedge clk_i) begin
        for (int d = 0; d < DEPTH; d++) begin
            if (wr_en[d]) mem_q[d] <= wr_data[d];
        end
    end

    // ---------------- control next state ----------------
    always_comb begin
        count_d  = count_q + (push ? n_push : '0) - CNT_W'(pop);
        wr_ptr_d = wr_ptr_q + (push ? PTR_W'(n_push) : '0);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        // Overflow is flagged for any ack the buffer could not take,
        // even one arriving together with a flush.
        ovf_d    = ovf_q | (bus.imem_ack_i && !ready);
        if (bus.flush_i) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
        end
    end

    // ---------------- head outputs ----------------
    dec_entry_t head;

    assign head = (count_q != '0) ? mem_q[rd_ptr_q] : '0;

    assign bus.imem_ready_o = ready;
    assign bus.dec_valid_o  = (count_q != '0);
    assign bus.func_o       = head.func;
    assign bus.we_o         = head.we;
    assign bus.rd_addr_o    = head.rd;
    assign bus.rs1_addr_o   = head.rs1;
    assign bus.rs2_addr_o   = head.rs2;
    assign bus.imm_o        = head.imm;
    assign bus.pc_o         = head.pc;
    assign bus.valid_pc_o   = head.valid_pc;
    assign bus.count_o      = count_q;
    assign bus.ovf_err_o    = ovf_q;

endmodule

// File: tb/tb_ins_dec_buf.sv
// ---------------------------------------------------------------------------
// tb_ins_dec_buf
// Directed scenarios plus a randomized run, all compared against a queue
// model of the decode buffer built directly from the instruction format.
// ---------------------------------------------------------------------------
module tb_ins_dec_buf;
    import simple_processor_pkg::*;

    localparam int DEPTH = 4;
    localparam int LANES = 2;

    typedef struct packed {
        logic [3:0]  func;
        logic        we;
        logic [2:0]  rd;
        logic [2:0]  rs1;
        logic [2:0]  rs2;
        logic [5:0]  imm;
        logic [31:0] pc;
        logic        valid_pc;
    } obs_t;

    logic clk;
    logic arst;
    int   checks = 0;
    int   errors = 0;

    obs_t model_q [$];
    logic model_ovf;

    ins_dec_buf_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(DEPTH)) bus ();

    ins_dec_buf #(.DATA_WIDTH(32), .INSTR_WIDTH(16), .ADDR_WIDTH(32), .DEPTH(DEPTH)) dut (
        .clk_i  (clk),
        .arst_i (arst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [15:0] mk(input logic [3:0] f, input logic [2:0] rd,
                                       input logic [2:0] rs1, input logic [2:0] rs2);
        return {rd, rs1, rs2, 3'b000, f};
    endfunction

    function automatic obs_t ref_decode(input logic [15:0] ins, input logic [31:0] pc);
        obs_t e;
        logic legal;
        legal      = ins[3:0] inside {ADD, SUB, AND, OR, XOR, NOT, ADDI,
                                      SLL, SLR, SLLI, SLRI, LOAD, STORE};
        e.func     = ins[3:0];
        e.we       = legal && (ins[3:0] != STORE);
        e.rd       = ins[15:13];
        e.rs1      = ins[12:10];
        e.rs2      = ins[9:7];
        e.imm      = ins[9:4];
        e.pc       = pc;
        e.valid_pc = legal;
        return e;
    endfunction

    function automatic obs_t exp_head();
        obs_t z = '0;
        return (model_q.size() != 0) ? model_q[0] : z;
    endfunction

    function automatic logic exp_ready();
        return (DEPTH - model_q.size()) >= LANES;
    endfunction

    function automatic obs_t observed();
        obs_t o;
        o.func     = bus.func_o;
        o.we       = bus.we_o;
        o.rd       = bus.rd_addr_o;
        o.rs1      = bus.rs1_addr_o;
        o.rs2      = bus.rs2_addr_o;
        o.imm      = bus.imm_o;
        o.pc       = bus.pc_o;
        o.valid_pc = bus.valid_pc_o;
        return o;
    endfunction

    task automatic model_step(input logic ack, input logic [31:0] addr,
                              input logic [31:0] data, input logic rdy, input logic fl);
        logic  can_take;
        int    s;
        can_take = exp_ready();
        if (ack && !can_take) model_ovf = 1'b1;
        if (fl) begin
            model_q.delete();
        end else begin
            if (rdy && model_q.size() != 0) void'(model_q.pop_front());
            if (ack && can_take) begin
                s = int'(addr[1]);
                for (int k = s; k < LANES; k++)
                    model_q.push_back(ref_decode(data[k*16 +: 16], (addr & ~32'h3) + 32'(2 * k)));
            end
        end
    endtask

    // One clock: drive inputs, advance the model, sample 1 ns after the edge.
    task automatic cycle(input logic ack, input logic [31:0] addr, input logic [31:0] data,
                         input logic rdy, input logic fl);
        bus.imem_ack_i   = ack;
        bus.imem_addr_i  = addr;
        bus.imem_rdata_i = data;
        bus.dec_ready_i  = rdy;
        bus.flush_i      = fl;
        model_step(ack, addr, data, rdy, fl);
        @(posedge clk);
        #1;
        bus.imem_ack_i  = 1'b0;
        bus.dec_ready_i = 1'b0;
        bus.flush_i     = 1'b0;
    endtask

    task automatic do_reset();
        arst             = 1'b1;
        bus.imem_ack_i   = 1'b0;
        bus.imem_addr_i  = '0;
        bus.imem_rdata_i = '0;
        bus.dec_ready_i  = 1'b0;
        bus.flush_i      = 1'b0;
        model_q.delete();
        model_ovf = 1'b0;
        @(posedge clk);
        #1;
        arst = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        arst = 1'b1;
        bus.imem_ack_i = 1'b0;
        bus.dec_ready_i = 1'b0;
        bus.flush_i = 1'b0;
        #2;
        checks++;
        if ({bus.dec_valid_o, bus.imem_ready_o, bus.count_o, bus.ovf_err_o} !== 6'b0_1_000_0) begin
            errors++;
            $display("FAIL reset_ctrl got valid=%b ready=%b count=%0d ovf=%b want 0 1 0 0",
                     bus.dec_valid_o, bus.imem_ready_o, bus.count_o, bus.ovf_err_o);
        end
        checks++;
        if (observed() !== obs_t'(0)) begin
            errors++;
            $display("FAIL reset_head got %h want 0", observed());
        end
        do_reset();
    endtask

    task automatic test_aligned();
        logic [31:0] w;
        do_reset();
        w = {mk(SUB, 3'd4, 3'd3, 3'd5), mk(ADD, 3'd3, 3'd1, 3'd2)};
        cycle(1'b1, 32'h0, w, 1'b1, 1'b0);
        checks++;
        if ({bus.count_o, bus.func_o, bus.pc_o, bus.we_o} !== {3'd2, ADD, 32'h0, 1'b1}) begin
            errors++;
            $display("FAIL aligned_first got count=%0d func=%0d pc=%h we=%b want 2 ADD 0 1",
                     bus.count_o, bus.func_o, bus.pc_o, bus.we_o);
        end
        checks++;
        if (observed() !== exp_head()) begin
            errors++;
            $display("FAIL aligned_head0 got %h want %h", observed(), exp_head());
        end
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        checks++;
        if ({bus.count_o, bus.func_o, bus.pc_o, bus.we_o, bus.rd_addr_o} !== {3'd1, SUB, 32'h2, 1'b1, 3'd4}) begin
            errors++;
            $display("FAIL aligned_second got count=%0d func=%0d pc=%h we=%b rd=%0d want 1 SUB 2 1 4",
                     bus.count_o, bus.func_o, bus.pc_o, bus.we_o, bus.rd_addr_o);
        end
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        checks++;
        if ({bus.count_o, bus.dec_valid_o} !== {3'd0, 1'b0}) begin
            errors++;
            $display("FAIL aligned_drain got count=%0d valid=%b want 0 0", bus.count_o, bus.dec_valid_o);
        end
    endtask

    task automatic test_unaligned();
        do_reset();
        cycle(1'b1, 32'h6, {mk(OR, 3'd2, 3'd6, 3'd7), mk(AND, 3'd1, 3'd1, 3'd1)}, 1'b0, 1'b0);
        checks++;
        if ({bus.count_o, bus.func_o, bus.pc_o} !== {3'd1, OR, 32'h6}) begin
            errors++;
            $display("FAIL unaligned got count=%0d func=%0d pc=%h want 1 OR 6",
                     bus.count_o, bus.func_o, bus.pc_o);
        end
        checks++;
        if (observed() !== exp_head()) begin
            errors++;
            $display("FAIL unaligned_head got %h want %h", observed(), exp_head());
        end
    endtask

    task automatic test_backpressure();
        obs_t held;
        do_reset();
        cycle(1'b1, 32'h100, {mk(XOR, 3'd5, 3'd1, 3'd2), mk(LOAD, 3'd6, 3'd2, 3'd0)}, 1'b0, 1'b0);
        cycle(1'b1, 32'h104, {mk(SLL, 3'd7, 3'd7, 3'd1), mk(NOT, 3'd1, 3'd4, 3'd0)}, 1'b0, 1'b0);
        checks++;
        if ({bus.count_o, bus.imem_ready_o} !== {3'd4, 1'b0}) begin
            errors++;
            $display("FAIL bp_full got count=%0d ready=%b want 4 0", bus.count_o, bus.imem_ready_o);
        end
        held = observed();
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        checks++;
        if (observed() !== held || held !== exp_head()) begin
            errors++;
            $display("FAIL bp_stall_stable got %h want %h", observed(), exp_head());
        end
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        checks++;
        if ({bus.count_o, bus.imem_ready_o, bus.pc_o} !== {3'd3, 1'b0, 32'h102}) begin
            errors++;
            $display("FAIL bp_pop1 got count=%0d ready=%b pc=%h want 3 0 102",
                     bus.count_o, bus.imem_ready_o, bus.pc_o);
        end
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        checks++;
        if ({bus.count_o, bus.imem_ready_o, bus.pc_o} !== {3'd2, 1'b1, 32'h104}) begin
            errors++;
            $display("FAIL bp_pop2 got count=%0d ready=%b pc=%h want 2 1 104",
                     bus.count_o, bus.imem_ready_o, bus.pc_o);
        end
    endtask

    task automatic test_illegal_store();
        do_reset();
        cycle(1'b1, 32'h40, {mk(STORE, 3'd2, 3'd3, 3'd4), mk(4'hF, 3'd1, 3'd1, 3'd1)}, 1'b0, 1'b0);
        checks++;
        if ({bus.valid_pc_o, bus.we_o, bus.pc_o} !== {1'b0, 1'b0, 32'h40}) begin
            errors++;
            $display("FAIL illegal got valid_pc=%b we=%b pc=%h want 0 0 40",
                     bus.valid_pc_o, bus.we_o, bus.pc_o);
        end
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        checks++;
        if ({bus.valid_pc_o, bus.we_o, bus.func_o} !== {1'b1, 1'b0, STORE}) begin
            errors++;
            $display("FAIL store got valid_pc=%b we=%b func=%0d want 1 0 STORE",
                     bus.valid_pc_o, bus.we_o, bus.func_o);
        end
    endtask

    task automatic test_flush();
        do_reset();
        cycle(1'b1, 32'h200, {mk(ADDI, 3'd1, 3'd2, 3'd3), mk(ADD, 3'd1, 3'd1, 3'd1)}, 1'b0, 1'b0);
        cycle(1'b1, 32'h206, {mk(SLRI, 3'd3, 3'd3, 3'd3), mk(SUB, 3'd2, 3'd2, 3'd2)}, 1'b0, 1'b0);
        checks++;
        if (bus.count_o !== 3'd3) begin
            errors++;
            $display("FAIL flush_pre got count=%0d want 3", bus.count_o);
        end
        cycle(1'b1, 32'h300, {mk(OR, 3'd7, 3'd7, 3'd7), mk(OR, 3'd6, 3'd6, 3'd6)}, 1'b1, 1'b1);
        checks++;
        if ({bus.count_o, bus.dec_valid_o} !== {3'd0, 1'b0}) begin
            errors++;
            $display("FAIL flush got count=%0d valid=%b want 0 0", bus.count_o, bus.dec_valid_o);
        end
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        checks++;
        if ({bus.count_o, observed()} !== {3'd0, obs_t'(0)}) begin
            errors++;
            $display("FAIL flush_absent got count=%0d head=%h want 0 0", bus.count_o, observed());
        end
    endtask

    task automatic test_random();
        logic        ack, rdy, fl;
        logic [31:0] addr, data;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            ack  = ($urandom_range(0, 2) != 0);
            rdy  = ($urandom_range(0, 9) < 6);
            fl   = ($urandom_range(0, 19) == 0);
            addr = $urandom;
            data = $urandom;
            if ($urandom_range(0, 3) == 0) data[3:0] = 4'(STORE);
            cycle(ack, addr, data, rdy, fl);
            checks++;
            if ({bus.count_o, bus.dec_valid_o, bus.imem_ready_o, bus.ovf_err_o} !==
                {3'(model_q.size()), model_q.size() != 0, exp_ready(), model_ovf}) begin
                errors++;
                $display("FAIL rand_ctrl[%0d] got count=%0d valid=%b ready=%b ovf=%b want %0d %b %b %b",
                         i, bus.count_o, bus.dec_valid_o, bus.imem_ready_o, bus.ovf_err_o,
                         model_q.size(), model_q.size() != 0, exp_ready(), model_ovf);
            end
            checks++;
            if (observed() !== exp_head()) begin
                errors++;
                $display("FAIL rand_head[%0d] got %h want %h", i, observed(), exp_head());
            end
        end
    endtask

    task automatic test_overflow_reset();
        do_reset();
        cycle(1'b1, 32'h0, {mk(ADD, 3'd1, 3'd1, 3'd1), mk(ADD, 3'd2, 3'd2, 3'd2)}, 1'b0, 1'b0);
        cycle(1'b1, 32'h4, {mk(ADD, 3'd3, 3'd3, 3'd3), mk(ADD, 3'd4, 3'd4, 3'd4)}, 1'b0, 1'b0);
        checks++;
        if (bus.ovf_err_o !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear got %b want 0", bus.ovf_err_o);
        end
        cycle(1'b1, 32'h8, {mk(SUB, 3'd5, 3'd5, 3'd5), mk(SUB, 3'd6, 3'd6, 3'd6)}, 1'b0, 1'b0);
        checks++;
        if ({bus.ovf_err_o, bus.count_o} !== {1'b1, 3'd4}) begin
            errors++;
            $display("FAIL ovf_set got ovf=%b count=%0d want 1 4", bus.ovf_err_o, bus.count_o);
        end
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        checks++;
        if ({bus.ovf_err_o, bus.count_o, bus.pc_o} !== {1'b1, 3'd2, 32'h4}) begin
            errors++;
            $display("FAIL ovf_sticky got ovf=%b count=%0d pc=%h want 1 2 4",
                     bus.ovf_err_o, bus.count_o, bus.pc_o);
        end
        #3;
        arst = 1'b1;
        #1;
        checks++;
        if ({bus.dec_valid_o, bus.imem_ready_o, bus.count_o, bus.ovf_err_o, observed()} !==
            {1'b0, 1'b1, 3'd0, 1'b0, obs_t'(0)}) begin
            errors++;
            $display("FAIL midcycle_reset got valid=%b ready=%b count=%0d ovf=%b head=%h want 0 1 0 0 0",
                     bus.dec_valid_o, bus.imem_ready_o, bus.count_o, bus.ovf_err_o, observed());
        end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_unaligned();
        test_backpressure();
        test_illegal_store();
        test_flush();
        test_random();
        test_overflow_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
